i2cm_sfifo_ctrl: RTL and testbench

//  Single-clock FIFO controller: read/write address generation, occupancy level, free space,

---
 rtl/i2cm_sfifo_ctrl_pkg.sv | 32 +++
 rtl/i2cm_ptr_wrap.sv | 47 ++++
 rtl/i2cm_sfifo_ctrl.sv | 149 ++++++++++++++
 tb/tb_i2cm_sfifo_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2cm_sfifo_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// i2cm_sfifo_ctrl_pkg
//   Shared definitions for the I2C-master synchronous FIFO controller:
//   ceiling-log2 helper used to size address/level fields, the packed
//   status-flag bundle and its reset/flush value.
// ---------------------------------------------------------------------------
package i2cm_sfifo_ctrl_pkg;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
  } ff_flags_t;

  // Value taken by the status flags on reset and on flush.
  localparam ff_flags_t FLAGS_RST = '{full: 1'b0, empty: 1'b1, afull: 1'b0, aempty: 1'b1};

endpackage

// File: rtl/i2cm_ptr_wrap.sv
// ---------------------------------------------------------------------------
// i2cm_ptr_wrap
//   Modulo-FIFO_DEP pointer register. Wraps from FIFO_DEP-1 to 0 so that
//   non-power-of-two depths address the RAM correctly.
// Ports
//   clk   in  1        clock
//   rst_n in  1        asynchronous active-low reset (pointer -> 0)
//   inc   in  1        advance pointer by one
//   clr   in  1        synchronous clear, priority over inc
//   ptr   out FIFO_AW  current pointer value
// ---------------------------------------------------------------------------
module i2cm_ptr_wrap #(
  parameter int unsigned FIFO_DEP = 8,
  parameter int unsigned FIFO_AW  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  input  logic               clr,
  output logic [FIFO_AW-1:0] ptr
);

  localparam logic [FIFO_AW-1:0] LAST = FIFO_AW'(FIFO_DEP - 1);

  logic [FIFO_AW-1:0] ptr_q;
  logic [FIFO_AW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + FIFO_AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/i2cm_sfifo_ctrl.sv
// ---------------------------------------------------------------------------
// i2cm_sfifo_ctrl
//   Single-clock FIFO controller for I2C-master TX/RX buffers. Generates the
//   1R1W RAM strobes and addresses, tracks occupancy/free space, and keeps
//   registered full/empty/almost flags, sticky overflow/underflow and a
//   peak-level watermark. FIFO_DEP may be any value >= 2.
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   push, pop            write / read requests
//   flush                synchronous flush (priority over push/pop)
//   err_clr              clears ff_ovf, ff_udf; reloads lvl_peak
//   afull_th, aempty_th  almost-full / almost-empty thresholds (LVL_W)
//   wr_en, rd_en         qualified RAM strobes (combinational)
//   waddr, raddr         RAM addresses (FIFO_AW)
//   ff_full .. ff_aempty registered status flags
//   ff_ovf, ff_udf       sticky error flags
//   fifo_lvl, fifo_free  stored / free entries (LVL_W)
//   lvl_peak             highest level since last err_clr
// ---------------------------------------------------------------------------
module i2cm_sfifo_ctrl
  import i2cm_sfifo_ctrl_pkg::*;
#(
  parameter  int unsigned FIFO_DEP = 8,
  localparam int unsigned FIFO_AW  = clog2(FIFO_DEP),
  localparam int unsigned LVL_W    = FIFO_AW + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic               err_clr,
  input  logic [LVL_W-1:0]   afull_th,
  input  logic [LVL_W-1:0]   aempty_th,
  output logic               wr_en,
  output logic               rd_en,
  output logic [FIFO_AW-1:0] waddr,
  output logic [FIFO_AW-1:0] raddr,
  output logic               ff_full,
  output logic               ff_empty,
  output logic               ff_afull,
  output logic               ff_aempty,
  output logic               ff_ovf,
  output logic               ff_udf,
  output logic [LVL_W-1:0]   fifo_lvl,
  output logic [LVL_W-1:0]   fifo_free,
  output logic [LVL_W-1:0]   lvl_peak
);

  localparam logic [LVL_W-1:0] DEP_L = LVL_W'(FIFO_DEP);

  ff_flags_t        flags_q, flags_d;
  logic [LVL_W-1:0] lvl_q,  lvl_d;
  logic [LVL_W-1:0] free_q, free_d;
  logic [LVL_W-1:0] peak_q, peak_d;
  logic             ovf_q,  ovf_d;
  logic             udf_q,  udf_d;

  // Qualification uses the registered flags, so a push while full / pop
  // while empty is dropped and push&pop at a boundary takes only one side.
  assign wr_en = push & ~flags_q.full  & ~flush;
  assign rd_en = pop  & ~flags_q.empty & ~flush;

  i2cm_ptr_wrap #(
    .FIFO_DEP (FIFO_DEP),
    .FIFO_AW  (FIFO_AW)
  ) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wr_en),
    .clr   (flush),
    .ptr   (waddr)
  );

  i2cm_ptr_wrap #(
    .FIFO_DEP (FIFO_DEP),
    .FIFO_AW  (FIFO_AW)
  ) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rd_en),
    .clr   (flush),
    .ptr   (raddr)
  );

  always_comb begin
    lvl_d = lvl_q;
    if (flush) begin
      lvl_d = '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   lvl_d = lvl_q + LVL_W'(1);
        2'b01:   lvl_d = lvl_q - LVL_W'(1);
        default: lvl_d = lvl_q;
      endcase
    end
  end

  // Flags are computed from the next level so they line up with it in the
  // cycle after the causing edge; flush returns them to the reset pattern
  // regardless of the thresholds.
  always_comb begin
    flags_d = FLAGS_RST;
    if (!flush) begin
      flags_d.full   = (lvl_d == DEP_L);
      flags_d.empty  = (lvl_d == '0);
      flags_d.afull  = (lvl_d >= afull_th);
      flags_d.aempty = (lvl_d <= aempty_th);
    end
  end

  assign free_d = DEP_L - lvl_d;

  // Set term is OR-ed after the clear so a same-cycle set wins over err_clr.
  assign ovf_d = (push & flags_q.full  & ~flush) | (ovf_q & ~err_clr);
  assign udf_d = (pop  & flags_q.empty & ~flush) | (udf_q & ~err_clr);

  // On flush lvl_d is 0, so the max leaves the watermark untouched.
  assign peak_d = err_clr ? lvl_d : ((lvl_d > peak_q) ? lvl_d : peak_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= FLAGS_RST;
      lvl_q   <= '0;
      free_q  <= DEP_L;
      peak_q  <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      lvl_q   <= lvl_d;
      free_q  <= free_d;
      peak_q  <= peak_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign ff_full   = flags_q.full;
  assign ff_empty  = flags_q.empty;
  assign ff_afull  = flags_q.afull;
  assign ff_aempty = flags_q.aempty;
  assign ff_ovf    = ovf_q;
  assign ff_udf    = udf_q;
  assign fifo_lvl  = lvl_q;
  assign fifo_free = free_q;
  assign lvl_peak  = peak_q;

endmodule

// File: tb/tb_i2cm_sfifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_i2cm_sfifo_ctrl
//   Directed and randomized bench for i2cm_sfifo_ctrl at FIFO_DEP=6. The
//   reference keeps occupancy as an integer count and pointers as counts
//   modulo the depth; flags are derived from the count at each edge.
// ---------------------------------------------------------------------------
module tb_i2cm_sfifo_ctrl;

  localparam int DEP = 6;
  localparam int AW  = 3;
  localparam int LW  = 4;

  logic          clk;
  logic          rst_n;
  logic          push, pop, flush, err_clr;
  logic [LW-1:0] afull_th, aempty_th;
  logic          wr_en, rd_en;
  logic [AW-1:0] waddr, raddr;
  logic          ff_full, ff_empty, ff_afull, ff_aempty, ff_ovf, ff_udf;
  logic [LW-1:0] fifo_lvl, fifo_free, lvl_peak;

  i2cm_sfifo_ctrl #(.FIFO_DEP(DEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .err_clr   (err_clr),
    .afull_th  (afull_th),
    .aempty_th (aempty_th),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .waddr     (waddr),
    .raddr     (raddr),
    .ff_full   (ff_full),
    .ff_empty  (ff_empty),
    .ff_afull  (ff_afull),
    .ff_aempty (ff_aempty),
    .ff_ovf    (ff_ovf),
    .ff_udf    (ff_udf),
    .fifo_lvl  (fifo_lvl),
    .fifo_free (fifo_free),
    .lvl_peak  (lvl_peak)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Reference state
  int m_lvl, m_w, m_r, m_peak;
  bit m_ovf, m_udf, m_af, m_ae;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lvl = 0; m_w = 0; m_r = 0; m_peak = 0;
    m_ovf = 0; m_udf = 0; m_af = 0; m_ae = 1;
  endtask

  task automatic chk_all();
    chk("fifo_lvl",  32'(fifo_lvl),  32'(m_lvl));
    chk("fifo_free", 32'(fifo_free), 32'(DEP - m_lvl));
    chk("ff_full",   32'(ff_full),   32'(m_lvl == DEP));
    chk("ff_empty",  32'(ff_empty),  32'(m_lvl == 0));
    chk("ff_afull",  32'(ff_afull),  32'(m_af));
    chk("ff_aempty", 32'(ff_aempty), 32'(m_ae));
    chk("ff_ovf",    32'(ff_ovf),    32'(m_ovf));
    chk("ff_udf",    32'(ff_udf),    32'(m_udf));
    chk("lvl_peak",  32'(lvl_peak),  32'(m_peak));
    chk("waddr",     32'(waddr),     32'(m_w));
    chk("raddr",     32'(raddr),     32'(m_r));
  endtask

  // One clock: drive at negedge, check strobes, update model at posedge,
  // check registered outputs 1 time unit later.
  task automatic cyc(input bit p, input bit q, input bit f, input bit e);
    bit we, re;
    int nl;
    @(negedge clk);
    push = p; pop = q; flush = f; err_clr = e;
    #1;
    we = p && (m_lvl != DEP) && !f;
    re = q && (m_lvl != 0) && !f;
    chk("wr_en", 32'(wr_en), 32'(we));
    chk("rd_en", 32'(rd_en), 32'(re));
    @(posedge clk);
    if (f) begin
      nl = 0; m_w = 0; m_r = 0;
    end else begin
      nl  = m_lvl + int'(we) - int'(re);
      m_w = (m_w + int'(we)) % DEP;
      m_r = (m_r + int'(re)) % DEP;
    end
    if (p && m_lvl == DEP && !f) m_ovf = 1; else if (e) m_ovf = 0;
    if (q && m_lvl == 0   && !f) m_udf = 1; else if (e) m_udf = 0;
    if (f) begin
      m_af = 0; m_ae = 1;
    end else begin
      m_af = (nl >= int'(afull_th));
      m_ae = (nl <= int'(aempty_th));
    end
    m_peak = e ? nl : ((nl > m_peak) ? nl : m_peak);
    m_lvl  = nl;
    #1;
    chk_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; push = 0; pop = 0; flush = 0; err_clr = 0;
    afull_th = 4'd4; aempty_th = 4'd1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    // 1. Reset then idle
    chk_all();
    cyc(0, 0, 0, 0);
    chk("idle_free6", 32'(fifo_free), 32'd6);

    // 2. Six pushes with wrap, then overflow push
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 0, 0);
      chk("push_waddr", 32'(waddr), 32'((i + 1) % 6));
      if (i == 2) chk("afull_before4", 32'(ff_afull), 32'd0);
      if (i == 3) chk("afull_after4",  32'(ff_afull), 32'd1);
    end
    chk("full_after6", 32'(ff_full), 32'd1);
    cyc(1, 0, 0, 0);
    chk("ovf_7th", 32'(ff_ovf), 32'd1);
    chk("lvl_7th", 32'(fifo_lvl), 32'd6);

    // 3. Level 3 with simultaneous push&pop; boundaries
    repeat (3) cyc(0, 1, 0, 0);
    repeat (5) cyc(1, 1, 0, 0);
    chk("pp_lvl3",   32'(fifo_lvl), 32'd3);
    chk("pp_waddr",  32'(waddr),    32'd5);
    chk("pp_raddr",  32'(raddr),    32'd2);
    repeat (3) cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    chk("full_pp_lvl5", 32'(fifo_lvl), 32'd5);
    repeat (5) cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    chk("empty_pp_lvl1", 32'(fifo_lvl), 32'd1);
    chk("empty_pp_udf",  32'(ff_udf),   32'd1);

    // 4. Fill to 5, err_clr, pop to 1
    repeat (4) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("clr_ovf",  32'(ff_ovf),   32'd0);
    chk("clr_udf",  32'(ff_udf),   32'd0);
    chk("clr_peak", 32'(lvl_peak), 32'd5);
    repeat (4) cyc(0, 1, 0, 0);
    chk("lvl1_aempty", 32'(ff_aempty), 32'd1);
    chk("lvl1_peak",   32'(lvl_peak),  32'd5);

    // 5. Level 4, flush + push
    repeat (3) cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    chk("flush_lvl",   32'(fifo_lvl), 32'd0);
    chk("flush_empty", 32'(ff_empty), 32'd1);
    chk("flush_peak",  32'(lvl_peak), 32'd5);

    // Threshold corners: afull_th=0 and aempty_th>=DEP force the flags
    afull_th = 4'd0; aempty_th = 4'd6;
    cyc(1, 0, 0, 0);
    chk("afull_th0",    32'(ff_afull),  32'd1);
    chk("aempty_th_ge", 32'(ff_aempty), 32'd1);
    afull_th = 4'd4; aempty_th = 4'd1;

    // 6. Asynchronous reset pulse between edges at level 4
    repeat (3) cyc(1, 0, 0, 0);
    chk("pre_rst_lvl4", 32'(fifo_lvl), 32'd4);
    @(negedge clk);
    push = 0; pop = 0; flush = 0; err_clr = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_all();
    #1 rst_n = 1'b1;
    cyc(0, 0, 0, 0);

    // Random traffic against the occupancy model
    for (int ph = 0; ph < 4; ph++) begin
      int bias;
      bias = (ph == 0) ? 70 : (ph == 1) ? 30 : (ph == 2) ? 50 : 85;
      for (int n = 0; n < 100; n++) begin
        bit p, q, f, e;
        p = ($urandom_range(0, 99) < bias);
        q = ($urandom_range(0, 99) < (100 - bias));
        f = ($urandom_range(0, 39) == 0);
        e = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 19) == 0) begin
          afull_th  = 4'($urandom_range(0, 8));
          aempty_th = 4'($urandom_range(0, 8));
        end
        cyc(p, q, f, e);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
